// File: rtl/xor_puf_pkg.sv
// Shared types, default parameters and the vote helper for the XOR arbiter-PUF controller.
package xor_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        SAMPLE,
        CLEAR,
        DONE
    } state_e;

    localparam int unsigned DEF_N_PUF      = 3;
    localparam int unsigned DEF_SETTLE_CYC = 8;
    localparam int unsigned DEF_N_EVAL     = 5;

    function automatic logic majority(input int unsigned cnt, input int unsigned n);
        return (cnt > (n / 2));
    endfunction

endpackage

// File: rtl/xor_puf_eval_ctrl_puf_sync.sv
// Per-bit two-flop synchroniser for the asynchronous arbiter outputs.
module puf_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/xor_puf_eval_ctrl.sv
// N-channel XOR arbiter-PUF sequencer with temporal majority vote and valid/ready output.
// Optional unanimity flag resp_stable is built when XOR_PUF_STAB_EN is defined.
module xor_puf_eval_ctrl
    import xor_puf_pkg::*;
#(
    parameter int unsigned N_PUF      = DEF_N_PUF,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned N_EVAL     = DEF_N_EVAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             arb_launch,
    output logic             arb_clr,
    input  logic [N_PUF-1:0] puf_in,
    output logic [N_PUF-1:0] puf_snap,
    output logic             raw_xor,
    output logic             resp,
    output logic             resp_valid,
    input  logic             resp_ready
`ifdef XOR_PUF_STAB_EN
    ,
    output logic             resp_stable
`endif
);

    localparam int unsigned CNT_W = $clog2(N_EVAL + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC);

    if ((N_EVAL % 2) == 0 || N_EVAL < 1) begin : g_bad_n_eval
        $error("N_EVAL must be odd and >= 1");
    end
    if (SETTLE_CYC < 3) begin : g_bad_settle
        $error("SETTLE_CYC must be >= 3");
    end
    if (N_PUF < 2) begin : g_bad_n_puf
        $error("N_PUF must be >= 2");
    end

    state_e             r_state;
    state_e             w_state_nxt;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [CNT_W-1:0]   r_eval_cnt;
    logic [CNT_W-1:0]   r_ones_cnt;
    logic [CNT_W-1:0]   w_ones_nxt;
    logic [N_PUF-1:0]   w_sync;
    logic               w_par;
    logic               w_last_eval;
    logic               w_settle_done;

    puf_sync #(
        .WIDTH (N_PUF)
    ) u_puf_sync (
        .clk (clk),
        .rst (rst),
        .i_d (puf_in),
        .o_q (w_sync)
    );

    assign w_par         = ^w_sync;
    assign w_last_eval   = (r_eval_cnt == CNT_W'(N_EVAL - 1));
    assign w_settle_done = (r_settle_cnt == SET_W'(SETTLE_CYC - 1));
    assign w_ones_nxt    = (w_par && (r_ones_cnt != CNT_W'(N_EVAL))) ?
                           r_ones_cnt + CNT_W'(1) : r_ones_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        arb_launch  = 1'b0;
        arb_clr     = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy    = 1'b0;
                arb_clr = 1'b1;
                if (start) w_state_nxt = LAUNCH;
            end
            LAUNCH: begin
                arb_launch  = 1'b1;
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                if (w_settle_done) w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                w_state_nxt = w_last_eval ? DONE : CLEAR;
            end
            CLEAR: begin
                arb_clr     = 1'b1;
                w_state_nxt = LAUNCH;
            end
            DONE: begin
                arb_clr = 1'b1;
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_eval_cnt   <= '0;
            r_ones_cnt   <= '0;
            puf_snap     <= '0;
            raw_xor      <= 1'b0;
            resp         <= 1'b0;
            resp_valid   <= 1'b0;
`ifdef XOR_PUF_STAB_EN
            resp_stable  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_eval_cnt <= '0;
                        r_ones_cnt <= '0;
                    end
                end
                LAUNCH: r_settle_cnt <= '0;
                SETTLE: r_settle_cnt <= r_settle_cnt + SET_W'(1);
                SAMPLE: begin
                    puf_snap   <= w_sync;
                    raw_xor    <= w_par;
                    r_ones_cnt <= w_ones_nxt;
                    r_eval_cnt <= r_eval_cnt + CNT_W'(1);
                    // Vote uses the count including this final sample.
                    if (w_last_eval) begin
                        resp       <= majority(32'(w_ones_nxt), N_EVAL);
                        resp_valid <= 1'b1;
`ifdef XOR_PUF_STAB_EN
                        resp_stable <= (w_ones_nxt == '0) ||
                                       (w_ones_nxt == CNT_W'(N_EVAL));
`endif
                    end
                end
                DONE: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_puf_eval_ctrl.sv
// Randomised self-checking bench for xor_puf_eval_ctrl against a vote-counting reference model.
module tb_xor_puf_eval_ctrl;

    localparam int N_PUF  = 3;
    localparam int SETTLE = 8;
    localparam int N_EVAL = 5;
    localparam int SPACE  = SETTLE + 3;
    localparam int LAT    = N_EVAL * SPACE - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             arb_launch;
    logic             arb_clr;
    logic [N_PUF-1:0] puf_in;
    logic [N_PUF-1:0] puf_snap;
    logic             raw_xor;
    logic             resp;
    logic             resp_valid;
    logic             resp_ready;
`ifdef XOR_PUF_STAB_EN
    logic             resp_stable;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [N_PUF-1:0] pat [N_EVAL];

    always #5 clk = ~clk;

    xor_puf_eval_ctrl #(
        .N_PUF      (N_PUF),
        .SETTLE_CYC (SETTLE),
        .N_EVAL     (N_EVAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .arb_launch (arb_launch),
        .arb_clr    (arb_clr),
        .puf_in     (puf_in),
        .puf_snap   (puf_snap),
        .raw_xor    (raw_xor),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
`ifdef XOR_PUF_STAB_EN
        ,
        .resp_stable (resp_stable)
`endif
    );

    function automatic logic [N_PUF-1:0] mk_pat(input logic p);
        logic [N_PUF-1:0] v;
        v = N_PUF'($urandom);
        if ((^v) != p) v[0] = ~v[0];
        return v;
    endfunction

    // Reference: number of evaluations whose channel parity is 1.
    function automatic int model_ones();
        int n;
        n = 0;
        for (int i = 0; i < N_EVAL; i++) n += int'(^pat[i]);
        return n;
    endfunction

    // Starts one response, presents pat[k] from launch k on, returns latency and launch timing.
    task automatic run_eval(input int inj_e, output int lat, output int n_launch,
                            output bit space_ok);
        int e;
        int last;
        lat      = -1;
        n_launch = 0;
        space_ok = 1'b1;
        last     = 0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e     = 0;
        while (e <= LAT + 20) begin
            start = (e == inj_e);
            if (arb_launch) begin
                if (n_launch > 0 && (e - last) != SPACE) space_ok = 1'b0;
                last = e;
                if (n_launch < N_EVAL) puf_in = pat[n_launch];
                n_launch++;
            end
            if (resp_valid) begin
                lat = e;
                break;
            end
            @(negedge clk);
            e++;
        end
        start = 1'b0;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        resp_ready = 1'b0;
        puf_in     = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, arb_launch, arb_clr} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy/launch/clr=%b want 001",
                     {busy, arb_launch, arb_clr});
        end
        n_tests++;
        if ({puf_snap, raw_xor, resp, resp_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got snap=%b raw=%b resp=%b valid=%b want all 0",
                     puf_snap, raw_xor, resp, resp_valid);
        end
`ifdef XOR_PUF_STAB_EN
        n_tests++;
        if (resp_stable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stable: got %b want 0", resp_stable);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_constant(input logic [N_PUF-1:0] v);
        int  lat, nl, ones;
        bit  sp;
        for (int i = 0; i < N_EVAL; i++) pat[i] = v;
        ones = model_ones();
        run_eval(-1, lat, nl, sp);
        n_tests++;
        if (lat !== LAT || nl !== N_EVAL || !sp) begin
            n_fail++;
            $display("FAIL const_timing: got lat=%0d launches=%0d spacing_ok=%0d want %0d/%0d/1",
                     lat, nl, sp, LAT, N_EVAL);
        end
        n_tests++;
        if (resp !== logic'(ones * 2 > N_EVAL) || raw_xor !== ^v || puf_snap !== v) begin
            n_fail++;
            $display("FAIL const_result: got resp=%b raw=%b snap=%b want %b/%b/%b",
                     resp, raw_xor, puf_snap, ones * 2 > N_EVAL, ^v, v);
        end
`ifdef XOR_PUF_STAB_EN
        n_tests++;
        if (resp_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL const_stable: got %b want 1", resp_stable);
        end
`endif
        release_resp();
    endtask

    task automatic test_alternating(input logic first);
        int  lat, nl, ones;
        bit  sp;
        for (int i = 0; i < N_EVAL; i++) pat[i] = mk_pat(first ^ logic'(i % 2));
        ones = model_ones();
        run_eval(-1, lat, nl, sp);
        n_tests++;
        if (lat !== LAT || resp !== logic'(ones * 2 > N_EVAL) || raw_xor !== ^pat[N_EVAL-1]) begin
            n_fail++;
            $display("FAIL alternating: got lat=%0d resp=%b raw=%b want %0d/%b/%b",
                     lat, resp, raw_xor, LAT, ones * 2 > N_EVAL, ^pat[N_EVAL-1]);
        end
`ifdef XOR_PUF_STAB_EN
        n_tests++;
        if (resp_stable !== 1'b0) begin
            n_fail++;
            $display("FAIL alternating_stable: got %b want 0", resp_stable);
        end
`endif
        release_resp();
    endtask

    task automatic test_random(input int iters);
        int  lat, nl, ones;
        bit  sp;
        for (int k = 0; k < iters; k++) begin
            for (int i = 0; i < N_EVAL; i++) pat[i] = N_PUF'($urandom);
            ones = model_ones();
            run_eval(-1, lat, nl, sp);
            n_tests++;
            if (lat !== LAT || resp !== logic'(ones * 2 > N_EVAL) ||
                puf_snap !== pat[N_EVAL-1] || raw_xor !== ^pat[N_EVAL-1]) begin
                n_fail++;
                $display("FAIL random[%0d]: got lat=%0d resp=%b snap=%b raw=%b want %0d/%b/%b/%b",
                         k, lat, resp, puf_snap, raw_xor, LAT, ones * 2 > N_EVAL,
                         pat[N_EVAL-1], ^pat[N_EVAL-1]);
            end
`ifdef XOR_PUF_STAB_EN
            n_tests++;
            if (resp_stable !== logic'(ones == 0 || ones == N_EVAL)) begin
                n_fail++;
                $display("FAIL random_stable[%0d]: got %b want %b",
                         k, resp_stable, ones == 0 || ones == N_EVAL);
            end
`endif
            release_resp();
        end
    endtask

    task automatic test_hold_done();
        int  lat, nl, ones;
        bit  sp;
        bit  bad;
        for (int i = 0; i < N_EVAL; i++) pat[i] = N_PUF'($urandom);
        ones = model_ones();
        run_eval(-1, lat, nl, sp);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            @(negedge clk);
            if (resp_valid !== 1'b1 || busy !== 1'b1 || resp !== logic'(ones * 2 > N_EVAL) ||
                raw_xor !== ^pat[N_EVAL-1] || puf_snap !== pat[N_EVAL-1]) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL hold_done: got valid=%b busy=%b resp=%b want 1/1/%b held 20 cycles",
                     resp_valid, busy, resp, ones * 2 > N_EVAL);
        end
        start      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        resp_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_release: got busy=%b valid=%b want 0/0", busy, resp_valid);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || arb_launch !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done_ignored: got busy=%b launch=%b want 0/0",
                     busy, arb_launch);
        end
    endtask

    task automatic test_start_in_settle();
        int  lat, nl, ones;
        bit  sp;
        for (int i = 0; i < N_EVAL; i++) pat[i] = N_PUF'($urandom);
        ones = model_ones();
        run_eval(SPACE + 4, lat, nl, sp);
        n_tests++;
        if (lat !== LAT || nl !== N_EVAL || !sp || resp !== logic'(ones * 2 > N_EVAL)) begin
            n_fail++;
            $display("FAIL start_in_settle: got lat=%0d launches=%0d resp=%b want %0d/%0d/%b",
                     lat, nl, resp, LAT, N_EVAL, ones * 2 > N_EVAL);
        end
        release_resp();
    endtask

    task automatic test_reset_mid();
        int  lat, nl, ones;
        bit  sp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * SPACE + 3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || arb_clr !== 1'b1 || resp_valid !== 1'b0 || arb_launch !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b clr=%b valid=%b launch=%b want 0/1/0/0",
                     busy, arb_clr, resp_valid, arb_launch);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N_EVAL; i++) pat[i] = N_PUF'($urandom);
        ones = model_ones();
        run_eval(-1, lat, nl, sp);
        n_tests++;
        if (lat !== LAT || nl !== N_EVAL || resp !== logic'(ones * 2 > N_EVAL)) begin
            n_fail++;
            $display("FAIL after_reset_run: got lat=%0d launches=%0d resp=%b want %0d/%0d/%b",
                     lat, nl, resp, LAT, N_EVAL, ones * 2 > N_EVAL);
        end
        release_resp();
    endtask

    initial begin
        test_reset();
        test_constant(3'b001);
        test_constant(3'b011);
        test_constant(3'b111);
        test_alternating(1'b1);
        test_alternating(1'b0);
        test_random(8);
        test_hold_done();
        test_start_in_settle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
